// File: rtl/alu_issue_stage_if.sv
// Handshake and data bundle between the issue stage, its instruction source and the ALU.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the instruction side; the ALU side is free-running.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] alu_A;
    logic [XLEN-1:0] alu_B;
    logic [31:0]     alu_instr;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
    logic            busy;

    // Environment side: instruction source, ALU result return and debug port.
    modport master (
        output in_valid, in_instr, alu_result, dbg_raddr,
        input  in_ready, alu_A, alu_B, alu_instr, dbg_rdata, busy
    );

    // Issue stage side.
    modport slave (
        input  in_valid, in_instr, alu_result, dbg_raddr,
        output in_ready, alu_A, alu_B, alu_instr, dbg_rdata, busy
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/operand-fetch stage for a 2-stage ALU: regfile, decode, bypass, stall, writeback.
// Latency: issue is combinational in the accept cycle; result written back two cycles later.
// Backpressure: in_ready drops for one cycle on a distance-1 RAW hazard and during reset.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic               clk,
    input logic               rst_n,
    alu_issue_stage_if.slave  io_bus
);

    localparam logic [6:0]      OP_R_TYPE    = 7'b0110011;
    localparam logic [6:0]      OP_I_TYPE    = 7'b0010011;
    localparam logic [31:0]     BUBBLE_INSTR = 32'h0000_0013;

    // In-flight tracker: slot 1 is in ALU stage 1, slot 2 is on alu_result now.
    logic                r_v1;
    logic [4:0]          r_rd1;
    logic                r_v2;
    logic [4:0]          r_rd2;

    // Integer register file; entry 0 is never written so it stays zero.
    logic [XLEN-1:0]     r_regfile [NREGS];

    // Decode
    logic [6:0]          w_opcode;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic                w_is_r;
    logic                w_is_i;
    logic                w_supported;
    logic [XLEN-1:0]     w_imm;
    logic                w_hazard;
    logic                w_ready;
    logic                w_issue;
    logic [XLEN-1:0]     w_op_rs1;
    logic [XLEN-1:0]     w_op_rs2;
    logic [XLEN-1:0]     w_alu_a;
    logic [XLEN-1:0]     w_alu_b;
    logic [31:0]         w_alu_instr;

    assign w_opcode    = io_bus.in_instr[6:0];
    assign w_rd        = io_bus.in_instr[11:7];
    assign w_rs1       = io_bus.in_instr[19:15];
    assign w_rs2       = io_bus.in_instr[24:20];
    assign w_is_r      = (w_opcode == OP_R_TYPE);
    assign w_is_i      = (w_opcode == OP_I_TYPE);
    assign w_supported = w_is_r || w_is_i;
    assign w_imm       = {{(XLEN-12){io_bus.in_instr[31]}}, io_bus.in_instr[31:20]};

    // Operand read: x0 is hard zero, then the result leaving the ALU, then the regfile.
    // The bypass also covers a writeback landing in the same cycle as the read.
    function automatic logic [XLEN-1:0] f_operand(
        input logic [4:0]      r,
        input logic [XLEN-1:0] rf_val,
        input logic            v2,
        input logic [4:0]      rd2,
        input logic [XLEN-1:0] result
    );
        if (r == 5'd0)
            return '0;
        else if (v2 && (rd2 == r))
            return result;
        else
            return rf_val;
    endfunction

    assign w_op_rs1 = f_operand(w_rs1, r_regfile[w_rs1], r_v2, r_rd2, io_bus.alu_result);
    assign w_op_rs2 = f_operand(w_rs2, r_regfile[w_rs2], r_v2, r_rd2, io_bus.alu_result);

    // A producer in ALU stage 1 has no result yet, so a consumer must wait one cycle
    // and pick it up from the bypass. Unsupported opcodes read nothing and never wait.
    // Checking slot 1 first also guarantees the youngest writer of a register wins.
    always_comb begin
        w_hazard = 1'b0;
        if (w_supported && r_v1 && (r_rd1 != 5'd0)) begin
            if (r_rd1 == w_rs1)
                w_hazard = 1'b1;
            else if (w_is_r && (r_rd1 == w_rs2))
                w_hazard = 1'b1;
        end
    end

    // Reset holds the stage closed regardless of clock activity.
    assign w_ready = rst_n && !w_hazard;
    assign w_issue = io_bus.in_valid && w_ready && w_supported;

    // ALU drive: real operands on issue, otherwise the canonical nop bubble.
    always_comb begin
        w_alu_instr = BUBBLE_INSTR;
        w_alu_a     = '0;
        w_alu_b     = '0;
        if (w_issue) begin
            w_alu_instr = io_bus.in_instr;
            w_alu_a     = w_op_rs1;
            w_alu_b     = w_is_r ? w_op_rs2 : w_imm;
        end
    end

    // Shift the in-flight tracker; bubbles and unsupported opcodes enter as empty slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_rd1 <= 5'd0;
            r_v2  <= 1'b0;
            r_rd2 <= 5'd0;
        end else begin
            r_v2  <= r_v1;
            r_rd2 <= r_rd1;
            r_v1  <= w_issue;
            r_rd1 <= w_issue ? w_rd : 5'd0;
        end
    end

    // Write back the emerging ALU result; reset clears the file and drops in-flight results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regfile[i] <= '0;
        end else if (r_v2 && (r_rd2 != 5'd0)) begin
            r_regfile[r_rd2] <= io_bus.alu_result;
        end
    end

    assign io_bus.in_ready  = w_ready;
    assign io_bus.alu_instr = w_alu_instr;
    assign io_bus.alu_A     = w_alu_a;
    assign io_bus.alu_B     = w_alu_b;
    assign io_bus.busy      = r_v1 | r_v2;
    // Debug view is the architectural file only, so a same-cycle writeback shows next cycle.
    assign io_bus.dbg_rdata = r_regfile[io_bus.dbg_raddr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 2-stage ALU closing the loop.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_issue_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.XLEN(32)) ifc ();

    alu_issue_stage #(.XLEN(32), .NREGS(32)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (ifc)
    );

    // Behavioural ALU: add/sub for R-type, add-immediate for I-type, two register stages.
    function automatic logic [31:0] alu_fn(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
        case (ins[6:0])
            7'h33:   return ins[30] ? (a - b) : (a + b);
            7'h13:   return a + b;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] alu_s1 = 32'd0;
    logic [31:0] alu_s2 = 32'd0;
    always @(posedge clk) begin
        alu_s1 <= alu_fn(ifc.alu_instr, ifc.alu_A, ifc.alu_B);
        alu_s2 <= alu_s1;
    end
    assign ifc.alu_result = alu_s2;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] instr);
        ifc.in_valid = v;
        ifc.in_instr = instr;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic rdreg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        ifc.dbg_raddr = addr;
        #1;
        chk(tag, ifc.dbg_rdata, exp);
    endtask

    initial begin
        ifc.dbg_raddr = 5'd0;
        drive(1'b1, 32'h0050_0093);

        // Reset state, with a valid instruction offered that must not be taken.
        #12;
        chk("rst_ready", ifc.in_ready, 32'd0);
        chk("rst_instr", ifc.alu_instr, 32'h0000_0013);
        chk("rst_A", ifc.alu_A, 32'd0);
        chk("rst_B", ifc.alu_B, 32'd0);
        chk("rst_busy", ifc.busy, 32'd0);
        for (int i = 0; i < 32; i++)
            rdreg($sformatf("rst_x%0d", i), 5'(i), 32'd0);
        next();
        rst_n = 1'b1;

        // Distance-1 stall then bypass: addi x1,5 ; addi x2,7 ; add x3,x1,x2
        mid();
        chk("c0_ready", ifc.in_ready, 32'd1);
        chk("c0_instr", ifc.alu_instr, 32'h0050_0093);
        chk("c0_A", ifc.alu_A, 32'd0);
        chk("c0_B", ifc.alu_B, 32'd5);
        next();
        drive(1'b1, 32'h0070_0113);
        mid();
        chk("c1_ready", ifc.in_ready, 32'd1);
        chk("c1_B", ifc.alu_B, 32'd7);
        chk("c1_busy", ifc.busy, 32'd1);
        next();
        drive(1'b1, 32'h0020_81B3);
        mid();
        chk("c2_ready", ifc.in_ready, 32'd0);
        chk("c2_instr", ifc.alu_instr, 32'h0000_0013);
        chk("c2_A", ifc.alu_A, 32'd0);
        chk("c2_res", ifc.alu_result, 32'd5);
        next();
        mid();
        chk("c3_ready", ifc.in_ready, 32'd1);
        chk("c3_instr", ifc.alu_instr, 32'h0020_81B3);
        chk("c3_A", ifc.alu_A, 32'd5);
        chk("c3_B", ifc.alu_B, 32'd7);
        next();
        drive(1'b0, 32'd0);
        next();
        next();
        mid();
        rdreg("c6_x3", 5'd3, 32'd12);
        rdreg("c6_x2", 5'd2, 32'd7);
        next();

        // Distance-2 bypass: addi x1,5 ; bubble ; sub x4,x3,x1
        drive(1'b1, 32'h0050_0093);
        next();
        drive(1'b0, 32'd0);
        next();
        drive(1'b1, 32'h4011_8233);
        mid();
        chk("d2_ready", ifc.in_ready, 32'd1);
        chk("d2_A", ifc.alu_A, 32'd12);
        chk("d2_B", ifc.alu_B, 32'd5);
        next();
        drive(1'b0, 32'd0);
        next();
        next();
        mid();
        rdreg("d5_x4", 5'd4, 32'd7);
        next();

        // Bypass to a register still zero in the file; debug port shows the old value.
        drive(1'b1, 32'h0640_0513);
        next();
        drive(1'b0, 32'd0);
        next();
        drive(1'b1, 32'h00A5_05B3);
        mid();
        chk("h2_ready", ifc.in_ready, 32'd1);
        chk("h2_A", ifc.alu_A, 32'd100);
        chk("h2_B", ifc.alu_B, 32'd100);
        rdreg("h2_x10_old", 5'd10, 32'd0);
        next();
        drive(1'b0, 32'd0);
        mid();
        rdreg("h3_x10_new", 5'd10, 32'd100);
        next();
        next();
        mid();
        rdreg("h5_x11", 5'd11, 32'd200);
        next();

        // Write-after-write at distance 1: addi x1,1 ; addi x1,2 ; addi x5,x1,0
        drive(1'b1, 32'h0010_0093);
        next();
        drive(1'b1, 32'h0020_0093);
        next();
        drive(1'b1, 32'h0000_8293);
        mid();
        chk("e2_ready", ifc.in_ready, 32'd0);
        next();
        mid();
        chk("e3_ready", ifc.in_ready, 32'd1);
        chk("e3_instr", ifc.alu_instr, 32'h0000_8293);
        chk("e3_A", ifc.alu_A, 32'd2);
        next();
        drive(1'b0, 32'd0);
        next();
        next();
        mid();
        rdreg("e6_x5", 5'd5, 32'd2);
        rdreg("e6_x1", 5'd1, 32'd2);
        next();

        // x0 destination, x0 bypass suppression, unsupported opcode, negative immediate.
        drive(1'b1, 32'h0090_0013);
        mid();
        chk("f0_ready", ifc.in_ready, 32'd1);
        next();
        drive(1'b1, 32'h0000_0333);
        mid();
        chk("f1_ready", ifc.in_ready, 32'd1);
        chk("f1_instr", ifc.alu_instr, 32'h0000_0333);
        chk("f1_A", ifc.alu_A, 32'd0);
        chk("f1_B", ifc.alu_B, 32'd0);
        next();
        drive(1'b1, 32'h0000_0613);
        mid();
        chk("f2_res", ifc.alu_result, 32'd9);
        chk("f2_A_x0", ifc.alu_A, 32'd0);
        next();
        drive(1'b1, 32'h0000_A403);
        mid();
        chk("f3_ready", ifc.in_ready, 32'd1);
        chk("f3_instr", ifc.alu_instr, 32'h0000_0013);
        chk("f3_A", ifc.alu_A, 32'd0);
        next();
        drive(1'b1, 32'hFFF0_0493);
        mid();
        chk("f4_ready", ifc.in_ready, 32'd1);
        chk("f4_B_sext", ifc.alu_B, 32'hFFFF_FFFF);
        next();
        drive(1'b0, 32'd0);
        next();
        next();
        mid();
        chk("f7_busy", ifc.busy, 32'd0);
        rdreg("f7_x0", 5'd0, 32'd0);
        rdreg("f7_x9", 5'd9, 32'hFFFF_FFFF);
        next();
        mid();
        rdreg("f8_x8", 5'd8, 32'd0);
        rdreg("f8_x1", 5'd1, 32'd2);
        next();

        // Reset mid-flight: addi x7,3 then reset the next cycle.
        drive(1'b1, 32'h0030_0393);
        mid();
        chk("g0_ready", ifc.in_ready, 32'd1);
        next();
        drive(1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("g1_busy", ifc.busy, 32'd0);
        chk("g1_ready", ifc.in_ready, 32'd0);
        chk("g1_instr", ifc.alu_instr, 32'h0000_0013);
        next();
        next();
        rst_n = 1'b1;
        next();
        next();
        mid();
        chk("g_busy", ifc.busy, 32'd0);
        rdreg("g_x7", 5'd7, 32'd0);
        rdreg("g_x3", 5'd3, 32'd0);
        next();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue and operand-fetch stage that sits directly upstream of the 2-stage ALU pipeline and drives its `A_in`, `B_in` and `instr_in` inputs. It holds the 32-entry integer register file and decodes R-type and I-type ALU instructions. It resolves read-after-write hazards against the ALU's two in-flight instructions by bypass or stall, and writes the ALU `Result_out` back into the register file when each result emerges.

## Interface
- `XLEN`, 32: datapath width.
- `NREGS`, 32: register count. Index width is 5 bits. x0 reads as zero.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: stage accepts `in_instr` this cycle.
- `in_instr` in 32: RV32 instruction word.
- `alu_A` out 32: to ALU `A_in`.
- `alu_B` out 32: to ALU `B_in`.
- `alu_instr` out 32: to ALU `instr_in`.
- `alu_result` in 32: from ALU `Result_out`.
- `dbg_raddr` in 5: debug register read address.
- `dbg_rdata` out 32: register file contents at `dbg_raddr`; combinational, no bypass.
- `busy` out 1: at least one instruction is in flight in the ALU.

## Operation
- Decode fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- Supported opcodes are 0110011 (R-type) and 0010011 (I-type).
- Any other opcode is accepted and consumed, issues as a bubble, and performs no writeback.
- Bubble is `alu_instr`=32'h0000_0013, `alu_A`=0, `alu_B`=0.
- A bubble is driven in every cycle with no issue: `in_valid`=0, a stall, or reset.
- Issue:
  - Issue occurs when `in_valid && in_ready` and the instruction is supported.
  - `alu_instr`=`in_instr` and `alu_A`=op(rs1).
  - R-type: `alu_B`=op(rs2).
  - I-type: `alu_B`=sign-extended `in_instr`[31:20].
  - The outputs are combinational from decode, register file and bypass.
- In-flight tracker, a 2-deep shift register of {v, rd}:
  - Slot 1 (v1, rd1) holds the instruction issued last cycle, now in ALU stage 1.
  - Slot 2 (v2, rd2) holds the instruction whose result is on `alu_result` this cycle.
  - Each edge: slot2 <= slot1; slot1 <= {issued supported instruction, rd}. Bubbles load v=0.
- Writeback: when v2 && rd2≠0, regfile[rd2] <= `alu_result` at the end of the cycle.
- Operand read op(r), in priority order:
  1. r=0 gives 0.
  2. v2 && rd2==r gives `alu_result` (bypass).
  3. Otherwise regfile[r].
- Hazard (stall):
  - Condition: v1 && rd1≠0 && (rd1==rs1 || (R-type && rd1==rs2)).
  - On hazard, `in_ready`=0 and a bubble is issued.
  - The instruction then issues the next cycle, taking the operand via bypass from slot 2.
- Unsupported opcodes never stall.
- Otherwise `in_ready`=1.
- `busy` = v1 | v2.

## Timing
- Issue latency: an instruction accepted in cycle t is presented to the ALU in cycle t, its result appears on `alu_result` in cycle t+2, and regfile is written at the end of t+2.
- Dependency distance 1: one stall cycle, then bypass. Distance 2: bypass, no stall. Distance ≥3: regfile.
- Throughput: 1 instruction/cycle with no dependency at distance 1.
- Two in-flight instructions writing the same rd: the reader stalls on slot 1, so it always receives the youngest value.
- Writeback and read of the same register in the same cycle: the bypass supplies the new value. `dbg_rdata` shows the old value until the next cycle.
- rd=x0: never written, never causes a hazard, never bypassed.
- Reset asserted at any time:
  - Immediately forces v1=v2=0, `in_ready`=0, bubble outputs and `busy`=0.
  - All regfile entries clear to 0.
  - In-flight results are discarded without writeback.
- First acceptance is possible in the first cycle after `rst_n` deasserts.

## Test plan
- Reset: with `rst_n`=0, check `in_ready`=0, `alu_instr`=0x00000013, `alu_A`=`alu_B`=0, `busy`=0, and `dbg_rdata`=0 for all 32 addresses.
- Distance-1 stall plus bypass:
  - Stimulus: cycle 0 issue 0x00500093 (addi x1,x0,5); cycle 1 issue 0x00700113 (addi x2,x0,7); cycle 2 present 0x002081B3 (add x3,x1,x2).
  - Required: `in_ready`=0 in cycle 2. In cycle 3 the add issues with `alu_A`=5, `alu_B`=7. `dbg_rdata`(x3)=12 in cycle 6.
- Distance-2 bypass:
  - Stimulus: addi x1,x0,5, then a bubble (`in_valid`=0), then 0x40118233 (sub x4,x3,x1) with x3=12.
  - Required: no stall; `alu_A`=12, `alu_B`=5 taken from `alu_result`. x4 becomes 7.
- Write-after-write, distance 1: addi x1,x0,1, then addi x1,x0,2, then addi x5,x1,0. Required: one stall cycle; x5=2.
- x0 and unsupported opcodes:
  - Stimulus: addi x0,x0,9, then add x6,x0,x0 back-to-back.
  - Required: no stall; x0 stays 0.
  - Stimulus: opcode 0000011 input.
  - Required: accepted, issues a bubble, no register changes.
- Reset mid-flight: issue addi x7,x0,3, then assert `rst_n`=0 one cycle later. Required: x7=0 after reset and `busy`=0 immediately.
